// File: rtl/img_pkg.sv
// Shared pixel width and colour-map mode encodings for the gray/RGB image path.
package img_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    MODE_REPL = 2'd0,
    MODE_JET  = 2'd1,
    MODE_HEAT = 2'd2,
    MODE_RSVD = 2'd3
  } cmap_mode_e;

endpackage

// File: rtl/pseudo_cmap.sv
// Registered gray -> RGB colour map; 2-cycle latency.
// No backpressure: r/g/b hold their last value whenever the output valid is low.
module pseudo_cmap
  import img_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [PIX_W-1:0] gray,
  input  cmap_mode_e       mode,
  output logic             out_vld,
  output logic [PIX_W-1:0] r,
  output logic [PIX_W-1:0] g,
  output logic [PIX_W-1:0] b
);

  logic             s1_vld;
  cmap_mode_e       s1_mode;
  logic [PIX_W-1:0] s1_gray;
  logic [1:0]       s1_seg;
  logic [PIX_W-1:0] s1_f4;
  logic [9:0]       s1_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_mode <= MODE_REPL;
      s1_gray <= '0;
      s1_seg  <= '0;
      s1_f4   <= '0;
      s1_t    <= '0;
    end else begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_mode <= mode;
        s1_gray <= gray;
        s1_seg  <= gray[7:6];
        s1_f4   <= {gray[5:0], 2'b00};
        s1_t    <= {2'b00, gray} + {1'b0, gray, 1'b0};
      end
    end
  end

  // Heat thresholds can go negative; keep one extra sign bit so nothing wraps.
  logic signed [10:0] heat_tg;
  logic signed [10:0] heat_tb;
  logic [PIX_W-1:0]   nxt_r, nxt_g, nxt_b;

  always_comb begin
    heat_tg = $signed({1'b0, s1_t}) - 11'sd255;
    heat_tb = $signed({1'b0, s1_t}) - 11'sd510;
    nxt_r   = s1_gray;
    nxt_g   = s1_gray;
    nxt_b   = s1_gray;
    case (s1_mode)
      MODE_JET: begin
        case (s1_seg)
          2'd0:    begin nxt_r = 8'd0;          nxt_g = s1_f4;         nxt_b = 8'd255;        end
          2'd1:    begin nxt_r = 8'd0;          nxt_g = 8'd255;        nxt_b = 8'd255 - s1_f4; end
          2'd2:    begin nxt_r = s1_f4;         nxt_g = 8'd255;        nxt_b = 8'd0;          end
          default: begin nxt_r = 8'd255;        nxt_g = 8'd255 - s1_f4; nxt_b = 8'd0;         end
        endcase
      end
      MODE_HEAT: begin
        nxt_r = (s1_t > 10'd255) ? 8'd255 : s1_t[7:0];
        if (heat_tg < 11'sd0)        nxt_g = 8'd0;
        else if (heat_tg > 11'sd255) nxt_g = 8'd255;
        else                         nxt_g = heat_tg[7:0];
        if (heat_tb < 11'sd0)        nxt_b = 8'd0;
        else if (heat_tb > 11'sd255) nxt_b = 8'd255;
        else                         nxt_b = heat_tb[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      r       <= '0;
      g       <= '0;
      b       <= '0;
    end else begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        r <= nxt_r;
        g <= nxt_g;
        b <= nxt_b;
      end
    end
  end

endmodule

// File: rtl/gray2rgb_pseudo.sv
// Gray pixel stream -> pseudo-colour RGB with frame markers; fixed 2-cycle latency.
// No backpressure: every input valid yields an output valid two cycles later.
module gray2rgb_pseudo
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gray_valid,
  input  logic [PIX_W-1:0] gray,
  input  logic [1:0]       mode,
  output logic             rgb_valid,
  output logic [PIX_W-1:0] r,
  output logic [PIX_W-1:0] g,
  output logic [PIX_W-1:0] b,
  output logic             sof,
  output logic             eol,
  output logic             eof
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_HEIGHT - 1);

  logic [CNT_W-1:0] col, row;
  cmap_mode_e       mode_lat;
  cmap_mode_e       eff_mode;
  logic             at_sof, at_eol, at_eof;

  always_comb begin
    at_sof   = (col == '0) && (row == '0);
    at_eol   = (col == COL_LAST);
    at_eof   = at_eol && (row == ROW_LAST);
    // The sof pixel already uses the newly sampled mode.
    eff_mode = at_sof ? cmap_mode_e'(mode) : mode_lat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      mode_lat <= MODE_REPL;
    end else if (gray_valid) begin
      if (at_sof) mode_lat <= cmap_mode_e'(mode);
      if (at_eol) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Marker delay line matches the two colour-map stages.
  logic [2:0] mk_s1, mk_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mk_s1 <= '0;
      mk_s2 <= '0;
    end else begin
      mk_s1 <= gray_valid ? {at_sof, at_eol, at_eof} : 3'b000;
      mk_s2 <= mk_s1;
    end
  end

  assign sof = mk_s2[2];
  assign eol = mk_s2[1];
  assign eof = mk_s2[0];

  pseudo_cmap u_cmap (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (gray_valid),
    .gray    (gray),
    .mode    (eff_mode),
    .out_vld (rgb_valid),
    .r       (r),
    .g       (g),
    .b       (b)
  );

endmodule

// File: tb/tb_gray2rgb_pseudo.sv
// Bench for gray2rgb_pseudo on a 4x3 frame: reference model + scoreboard checked every cycle.
module tb_gray2rgb_pseudo;

  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       gray_valid;
  logic [7:0] gray;
  logic [1:0] mode;
  logic       rgb_valid;
  logic [7:0] r, g, b;
  logic       sof, eol, eof;

  gray2rgb_pseudo #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray_valid (gray_valid),
    .gray       (gray),
    .mode       (mode),
    .rgb_valid  (rgb_valid),
    .r          (r),
    .g          (g),
    .b          (b),
    .sof        (sof),
    .eol        (eol),
    .eof        (eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] r, g, b;
    logic       sof, eol, eof;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   m_col = 0, m_row = 0, m_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [23:0] model_rgb(input int m, input int gy);
    int s, f, t, rr, gg, bb;
    rr = gy; gg = gy; bb = gy;
    if (m == 1) begin
      s = gy / 64;
      f = (gy % 64) * 4;
      case (s)
        0:       begin rr = 0;   gg = f;       bb = 255;     end
        1:       begin rr = 0;   gg = 255;     bb = 255 - f; end
        2:       begin rr = f;   gg = 255;     bb = 0;       end
        default: begin rr = 255; gg = 255 - f; bb = 0;       end
      endcase
    end else if (m == 2) begin
      t  = 3 * gy;
      rr = (t > 255) ? 255 : t;
      gg = (t - 255 < 0) ? 0 : ((t - 255 > 255) ? 255 : t - 255);
      bb = (t - 510 < 0) ? 0 : ((t - 510 > 255) ? 255 : t - 510);
    end
    return {rr[7:0], gg[7:0], bb[7:0]};
  endfunction

  task automatic push_model(input int gy, input int m);
    exp_t e;
    logic [23:0] c;
    e.cyc = cyc;
    e.sof = (m_col == 0 && m_row == 0);
    e.eol = (m_col == W - 1);
    e.eof = e.eol && (m_row == H - 1);
    if (e.sof) m_mode = m;
    c = model_rgb(m_mode, gy);
    {e.r, e.g, e.b} = c;
    exp_q.push_back(e);
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row = (m_row == H - 1) ? 0 : m_row + 1;
    end
  endtask

  task automatic drive(input logic v, input int gy, input int m);
    @(negedge clk);
    gray_valid = v;
    gray       = gy[7:0];
    mode       = m[1:0];
    if (v) push_model(gy, m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0);
  endtask

  task automatic align(input int m);
    int k;
    k = 0;
    while ((m_col != 0 || m_row != 0) && k < 64) begin
      drive(1'b1, 17 * k + 3, m);
      k++;
    end
  endtask

  // Scoreboard: every cycle either the next expected pixel appears or outputs stay idle.
  logic [7:0] last_r = 0, last_g = 0, last_b = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_r = 0; last_g = 0; last_b = 0;
    end else if (exp_q.size() > 0 && exp_q[0].cyc + 2 == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("valid_on_pixel", {31'd0, rgb_valid}, 32'd1);
      chk("rgb", {8'd0, r, g, b}, {8'd0, e.r, e.g, e.b});
      chk("markers", {29'd0, sof, eol, eof}, {29'd0, e.sof, e.eol, e.eof});
      last_r = e.r; last_g = e.g; last_b = e.b;
    end else begin
      chk("valid_idle", {31'd0, rgb_valid}, 32'd0);
      chk("markers_idle", {29'd0, sof, eol, eof}, 32'd0);
      chk("rgb_hold", {8'd0, r, g, b}, {8'd0, last_r, last_g, last_b});
    end
  end

  initial begin
    logic [23:0] jet_exp [5];
    int          jet_in  [5];
    logic [23:0] heat_exp[4];
    int          heat_in [4];
    jet_in   = '{0, 64, 128, 200, 255};
    jet_exp  = '{24'h0000FF, 24'h00FFFF, 24'h00FF00, 24'hFFDF00, 24'hFF0300};
    heat_in  = '{50, 100, 200, 255};
    heat_exp = '{24'h960000, 24'hFF2D00, 24'hFFFF5A, 24'hFFFFFF};

    // Pin the reference model against hand-computed colours.
    for (int i = 0; i < 5; i++) chk("model_jet", {8'd0, model_rgb(1, jet_in[i])}, {8'd0, jet_exp[i]});
    for (int i = 0; i < 4; i++) chk("model_heat", {8'd0, model_rgb(2, heat_in[i])}, {8'd0, heat_exp[i]});
    chk("model_rsvd", {8'd0, model_rgb(3, 77)}, 32'h004D4D4D);

    rst_n = 1'b0; gray_valid = 1'b0; gray = 8'd0; mode = 2'd0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_outputs", {7'd0, rgb_valid, r, g, b}, 32'd0);
    chk("reset_markers", {29'd0, sof, eol, eof}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 77, 0);
    idle(1);
    drive(1'b0, 0, 0);
    #1;
    chk("first_pixel_valid", {31'd0, rgb_valid}, 32'd1);
    chk("first_pixel_rgb", {8'd0, r, g, b}, 32'h004D4D4D);
    chk("first_pixel_sof", {31'd0, sof}, 32'd1);
    align(0);
    idle(3);

    for (int i = 0; i < 5; i++) drive(1'b1, jet_in[i], 1);
    align(1);
    idle(2);

    for (int i = 0; i < 4; i++) drive(1'b1, heat_in[i], 2);
    align(2);
    idle(2);

    for (int i = 0; i < 24; i++) drive(1'b1, (i * 37 + 5) % 256, (i < 12) ? 0 : 3);
    idle(3);

    // Mode change mid-frame with valid gaps; new mode applies only from the next sof.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, i * 21 + 2, (i >= 5) ? 2 : 1);
      if (i % 3 == 1) drive(1'b0, 0, 2);
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 255 - i * 19, 2);
      if (i % 4 == 2) drive(1'b0, 0, 1);
    end
    idle(3);

    for (int i = 0; i < 6; i++) drive(1'b1, i * 40 + 10, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    gray_valid = 1'b0;
    exp_q.delete();
    m_col = 0; m_row = 0; m_mode = 0;
    #1;
    chk("async_reset_outputs", {7'd0, rgb_valid, r, g, b}, 32'd0);
    chk("async_reset_markers", {29'd0, sof, eol, eof}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 99, 2);
    for (int i = 0; i < 5; i++) drive(1'b1, i * 50, 2);
    idle(4);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray2rgb_pseudo.md
Name: gray2rgb_pseudo

Overview:
Inverse-direction companion to the RGB-to-gray stage. It takes the 8-bit gray pixel stream (gray_valid/gray) and expands each pixel to 8-bit R/G/B through a selectable colour map: replicate, jet or heat.
- Tracks pixel position inside the frame and emits start-of-frame, end-of-line and end-of-frame markers aligned with the output pixel.
- Sits after grayscale processing and feeds the display/PPM-dump path.

Parameters:
IMG_WIDTH, 640, pixels per line (>=2)
IMG_HEIGHT, 480, lines per frame (>=2)
CNT_W, 12, width of column/row counters; must satisfy 2^CNT_W > max(IMG_WIDTH, IMG_HEIGHT)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
gray_valid  in  1  input pixel qualifier, one pixel per asserted cycle, no backpressure
gray  in  8  gray pixel value
mode  in  2  colour map: 0 replicate, 1 jet, 2 heat, 3 reserved (behaves as 0)
rgb_valid  out  1  output pixel qualifier
r  out  8  red
g  out  8  green
b  out  8  blue
sof  out  1  high with the first pixel of a frame
eol  out  1  high with the last pixel of each line
eof  out  1  high with the last pixel of a frame

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: rgb_valid, r, g, b, sof, eol, eof = 0. Column and row counters = 0. Latched mode = 0.
- Reset mid-frame: all pipeline contents are discarded. The next valid pixel is treated as column 0, row 0 (sof).
- Latency: fixed 2 cycles.
  - Stage 1 registers the value, segment/arith products, mode and position flags.
  - Stage 2 registers the outputs.
  - rgb_valid(t+2) = gray_valid(t). Gaps in gray_valid propagate unchanged; no bubbles are inserted or removed.
- While rgb_valid = 0: r, g, b hold their last values; sof, eol and eof are 0.
- Position counters advance only on gray_valid.
  - col increments each valid pixel. At col = IMG_WIDTH-1 it wraps to 0 and row increments.
  - At row = IMG_HEIGHT-1 and col = IMG_WIDTH-1, both wrap to 0.
- Markers are computed from counter values at input time and delayed with the pixel:
  - sof when col = 0 and row = 0.
  - eol when col = IMG_WIDTH-1.
  - eof when eol and row = IMG_HEIGHT-1.
- Mode latching: mode is sampled only on the sof pixel and held for the whole frame. Mid-frame mode changes take effect at the next frame.
- Replicate map (mode 0/3): r = g = b = gray.
- Jet map: s = gray[7:6], f4 = {gray[5:0], 2'b00}, range 0..252.
  - s0: (0, f4, 255)
  - s1: (0, 255, 255 - f4)
  - s2: (f4, 255, 0)
  - s3: (255, 255 - f4, 0)
- Heat map: t = 3*gray, 10-bit, range 0..765.
  - r = min(t, 255)
  - g = clamp(t - 255, 0, 255)
  - b = clamp(t - 510, 0, 255)
  - Signed/extended intermediate arithmetic is required; outputs never wrap.
- Back-to-back frames: after the eof pixel, the next valid pixel is sof with no idle cycle required.

Decomposition:
- Shared package (img_pkg): mode encodings MODE_REPL = 2'd0, MODE_JET = 2'd1, MODE_HEAT = 2'd2, MODE_RSVD = 2'd3, plus the PIX_W = 8 constant.
- One natural sub-module, pseudo_cmap: registered colour-map datapath (gray, mode in; r/g/b out, 2 stages).
- The top level holds the counters, mode latch and marker delay line.

Test Plan:
- Reset: hold rst_n = 0 for 5 cycles -> all outputs 0. Release, apply one pixel gray = 77 with mode 0 -> 2 cycles later rgb_valid = 1, (77, 77, 77), sof = 1.
- Jet map: mode 1, pixels 0, 64, 128, 200, 255 back-to-back -> (0,0,255), (0,255,255), (0,255,0), (255,223,0), (255,3,0), each 2 cycles after its input.
- Heat map: mode 2, pixels 50, 100, 200, 255 -> (150,0,0), (255,45,0), (255,255,90), (255,255,255); no wrap.
- Markers: IMG_WIDTH = 4, IMG_HEIGHT = 3, 24 continuous pixels.
  - sof at output pixels 0 and 12.
  - eol at pixels 3, 7, 11, 15, 19, 23.
  - eof at pixels 11 and 23.
- Mode latch and gaps: switch mode 1 -> 2 at pixel 5 of a 12-pixel frame, with gray_valid toggling 1-0-1 -> whole frame jet-mapped, next frame heat-mapped, valid gaps reproduced exactly.
- Async reset mid-frame: assert rst_n at pixel 6 between clock edges -> outputs go to 0 immediately. Next pixel after release carries sof = 1.
